fetch_unit: RTL and testbench

Instruction fetch stage, directly upstream of the main decoder. Holds the PC and issues in-order word requests to instruction memory. Buffers returned words in a small FIFO and presents them, with their PC and extracted opcode, to decode via a valid/ready handshake. Branch redirects flush the buffer and discard responses still in flight.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited in-order memory requests, instruction buffer to decode.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall,
`endif
    input  logic            instr_ready
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'(3);

    logic [XLEN-1:0] pc, resp_pc, target;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] buf_data [FIFO_DEPTH];
    logic [XLEN-1:0] buf_pc   [FIFO_DEPTH];
    logic [CW:0]     credit_used;
    logic            issue, resp_take, push, pop;

    // Requests in flight plus buffered words never exceed the buffer size, so a push always has room.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc & ALIGN_M;
    assign target         = redirect_pc & ALIGN_M;

    assign issue     = imem_req_valid && imem_req_ready;
    assign resp_take = imem_resp_valid && (outstanding != '0);
    assign push      = resp_take && (drop_cnt == '0) && !redirect_valid;

    assign instr_valid = !rst && !redirect_valid && (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? buf_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : '0;
    assign opcode      = instr[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight belongs to the abandoned path and must be discarded.
            pc          <= target;
            resp_pc     <= target;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding - CW'(resp_take);
            drop_cnt    <= outstanding - CW'(resp_take);
        end else begin
            if (issue)
                pc <= pc + XLEN'(4);
            outstanding <= outstanding + CW'(issue) - CW'(resp_take);
            if (resp_take && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_resp_data;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + XLEN'(1);
            if (instr_ready && !instr_valid)
                perf_stall <= perf_stall + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect traffic against an epoch-based stream model.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];   // requests accepted by memory, in order
    logic [31:0] bufq[$];   // addresses of words that decode will see, in order
    logic [31:0] exp_pc;
    int          epoch;
    int          cyc;
    int          perf_f, perf_s;
    int          n_chk, n_pass;
    int          p_ready, p_iready, p_redir, lat_min, lat_max;
    bit          stray;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive_rand();
        imem_req_ready = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_iready);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
    endtask

    // One clock cycle: present memory response, check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic        resp, e_rv, e_iv;
        logic [31:0] e_instr, e_ipc;
        req_t        r;
        resp            = (memq.size() != 0) && (memq[0].due <= cyc);
        imem_resp_valid = resp || (stray && memq.size() == 0);
        imem_resp_data  = resp ? mem_word(memq[0].addr) : $urandom;
        #2;
        e_rv    = !rst && !redirect_valid && ((memq.size() + bufq.size()) < DEPTH);
        e_iv    = !rst && !redirect_valid && (bufq.size() != 0);
        e_ipc   = e_iv ? bufq[0] : 32'h0;
        e_instr = e_iv ? mem_word(bufq[0]) : 32'h0;
        chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
        if (e_rv) chk("req_addr", imem_req_addr, exp_pc);
        chk("instr_valid", 32'(instr_valid), 32'(e_iv));
        chk("instr", instr, e_instr);
        chk("instr_pc", instr_pc, e_ipc);
        chk("opcode", 32'(opcode), {25'h0, e_instr[6:0]});
`ifdef FETCH_PERF_CNT_EN
        if (!rst) begin
            chk("perf_fetched", perf_fetched, perf_f);
            chk("perf_stall", perf_stall, perf_s);
        end
`endif
        @(posedge clk);
        if (rst) begin
            exp_pc = 32'h0;
            bufq.delete();
            memq.delete();
            epoch++;
            perf_f = 0;
            perf_s = 0;
        end else begin
            if (e_iv && instr_ready) perf_f++;
            if (instr_ready && !e_iv) perf_s++;
            if (resp) r = memq.pop_front();
            if (redirect_valid) begin
                bufq.delete();
                epoch++;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (e_iv && instr_ready) void'(bufq.pop_front());
                if (resp && r.epoch == epoch) bufq.push_back(r.addr);
                if (e_rv && imem_req_ready) begin
                    memq.push_back('{exp_pc, epoch, cyc + 1 + $urandom_range(lat_max, lat_min)});
                    exp_pc += 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        p_ready = 0; p_redir = 0; p_iready = 100;
        for (int i = 0; i < 40 && memq.size() != 0; i++) begin
            drive_rand();
            tick();
        end
        chk("drain_timeout", 32'(memq.size()), 32'h0);
    endtask

    task automatic rst_seq();
        drain();
        rst = 1'b1;
        drive_rand();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_rand();
            tick();
        end
    endtask

    initial begin
        bit hit;
        n_chk = 0; n_pass = 0; cyc = 0; epoch = 0; exp_pc = 32'h0;
        perf_f = 0; perf_s = 0; stray = 1'b0;
        p_ready = 0; p_iready = 0; p_redir = 0; lat_min = 0; lat_max = 0;
        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        @(posedge clk); #1;
        rst_seq();

        // Streaming fetch with single-cycle memory
        p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 0; lat_max = 0;
        run(10);

        // Decode stalled: credit stops requests at the buffer size, one pop frees one slot
        rst_seq();
        p_ready = 100; p_iready = 0;
        run(6);
        p_iready = 100; run(1);
        p_iready = 0;   run(4);

        // Redirect with two requests in flight
        rst_seq();
        p_ready = 100; p_iready = 0; lat_min = 4; lat_max = 4;
        run(2);
        chk("inflight_before_redirect", 32'(memq.size()), 32'd2);
        drive_rand();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        lat_min = 0; lat_max = 0; p_iready = 100;
        run(10);

        // Redirect coinciding with a response and a pop
        rst_seq();
        p_ready = 100; p_iready = 0; hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive_rand();
            if (bufq.size() != 0 && memq.size() != 0 && memq[0].due <= cyc) begin
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b1; hit = 1'b1;
            end
            tick();
        end
        chk("redirect_collision_reached", 32'(hit), 32'h1);
        p_iready = 100;
        run(10);

        // Stray response with nothing outstanding
        rst_seq();
        p_ready = 0; p_iready = 100;
        stray = 1'b1; run(1); stray = 1'b0;
        run(3);
        p_ready = 100;
        run(8);

        // Randomized traffic including redirects and variable latency
        p_ready = 70; p_iready = 70; p_redir = 5; lat_min = 0; lat_max = 3;
        run(3000);
        p_redir = 0; p_ready = 100; p_iready = 100; lat_max = 0;
        run(20);

        // Reset clears everything, including counters
        rst_seq();
        p_ready = 100; p_iready = 100;
        run(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
